// File: rtl/ofdm_frame_ctrl_pkg.sv
// rtl/ofdm_frame_ctrl_pkg.sv - state encoding and default geometry for the OFDM frame sequencer
package ofdm_frame_ctrl_pkg;

    localparam int DEF_N_FFT  = 64;
    localparam int DEF_CP_LEN = 16;
    localparam int DEF_SYMS   = 8;
    localparam int DEF_GAP    = 4;
    localparam int DEF_ADDR_W = 6;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SYM = 3'd1,
        CP       = 3'd2,
        BODY     = 3'd3,
        GAP      = 3'd4
    } state_t;

endpackage

// File: rtl/ofdm_seq_cnt.sv
// rtl/ofdm_seq_cnt.sv - loadable modulo-MOD counter with terminal-count flag
module ofdm_seq_cnt #(
    parameter int WIDTH = 6,
    parameter int MOD   = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

    assign tc = (count == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= tc ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ofdm_frame_ctrl.sv
// rtl/ofdm_frame_ctrl.sv - OFDM frame sequencer: CP + body readout, sop/eop, inter-frame gap
// Optional UNDERRUN_CNT_EN adds a saturating underrun cycle counter output.
module ofdm_frame_ctrl
    import ofdm_frame_ctrl_pkg::*;
#(
    parameter int N_FFT          = DEF_N_FFT,
    parameter int CP_LEN         = DEF_CP_LEN,
    parameter int SYMS_PER_FRAME = DEF_SYMS,
    parameter int GAP_LEN        = DEF_GAP,
    parameter int ADDR_W         = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              ready_in,
    input  logic              sym_rdy,
`ifdef UNDERRUN_CNT_EN
    output logic [15:0]       underrun_cnt,
`endif
    output logic              buf_rd,
    output logic [ADDR_W-1:0] buf_addr,
    output logic              sym_done,
    output logic              valid_OFDM,
    output logic              sop,
    output logic              eop,
    output logic [7:0]        sym_idx,
    output logic              frame_busy
);

    localparam int GAP_W = (GAP_LEN < 2) ? 1 : $clog2(GAP_LEN);
    localparam logic [ADDR_W-1:0] START = (CP_LEN == 0) ? '0 : ADDR_W'(N_FFT - CP_LEN);
    localparam state_t FIRST_ST = (CP_LEN == 0) ? BODY : CP;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic              addr_tc, addr_load;
    logic [GAP_W-1:0]  gap_cnt_unused;
    logic              gap_tc, gap_load, gap_inc;
    logic              rd_issue, last_sym, end_body, first_rd;
    logic              sop_rd, eop_rd;

    ofdm_seq_cnt #(.WIDTH(ADDR_W), .MOD(N_FFT)) u_addr_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (addr_load),
        .load_val (START),
        .inc      (rd_issue),
        .count    (addr),
        .tc       (addr_tc)
    );

    ofdm_seq_cnt #(.WIDTH(GAP_W), .MOD(GAP_LEN)) u_gap_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (gap_load),
        .load_val ('0),
        .inc      (gap_inc),
        .count    (gap_cnt_unused),
        .tc       (gap_tc)
    );

    assign last_sym   = (sym_idx == 8'(SYMS_PER_FRAME - 1));
    assign end_body   = (state == BODY) && rd_issue && addr_tc;
    assign first_rd   = (state == FIRST_ST) && (addr == START);
    assign frame_busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // CP ends at address N_FFT-1 and wraps into body address 0, so one
    // terminal-count flag closes both the CP and the body phases.
    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        addr_load = 1'b0;
        gap_load  = 1'b0;
        gap_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = WAIT_SYM;
            end
            WAIT_SYM: begin
                if (sym_rdy && !sym_done) begin
                    state_nxt = FIRST_ST;
                    addr_load = 1'b1;
                end
            end
            CP: begin
                rd_issue = ready_in;
                if (ready_in && addr_tc) state_nxt = BODY;
            end
            BODY: begin
                rd_issue = ready_in;
                if (ready_in && addr_tc) begin
                    if (last_sym) begin
                        state_nxt = GAP;
                        gap_load  = 1'b1;
                    end else begin
                        state_nxt = WAIT_SYM;
                    end
                end
            end
            GAP: begin
                gap_inc = 1'b1;
                if (gap_tc) state_nxt = enable ? WAIT_SYM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_rd     <= 1'b0;
            buf_addr   <= '0;
            sop_rd     <= 1'b0;
            eop_rd     <= 1'b0;
            sym_done   <= 1'b0;
            valid_OFDM <= 1'b0;
            sop        <= 1'b0;
            eop        <= 1'b0;
            sym_idx    <= '0;
        end else begin
            buf_rd     <= rd_issue;
            sop_rd     <= rd_issue && first_rd;
            eop_rd     <= end_body && last_sym;
            sym_done   <= end_body;
            valid_OFDM <= buf_rd;
            sop        <= sop_rd;
            eop        <= eop_rd;
            if (rd_issue) buf_addr <= addr;
            if (end_body) sym_idx <= last_sym ? 8'd0 : sym_idx + 8'd1;
        end
    end

`ifdef UNDERRUN_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            underrun_cnt <= '0;
        end else if ((state == WAIT_SYM) && !sym_rdy && (sym_idx != 8'd0)
                     && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ofdm_frame_ctrl.sv
// tb/tb_ofdm_frame_ctrl.sv - randomized self-checking bench for ofdm_frame_ctrl (CP and no-CP instances)
module tb_ofdm_frame_ctrl;

    localparam int NA = 64, CPA = 16, SA = 8, GA = 4;
    localparam int NB = 16, CPB = 0,  SB = 2, GB = 2;

    logic clock = 1'b0, reset = 1'b0, enable = 1'b0, ready_in = 1'b0, sym_rdy = 1'b0;
    logic buf_rd_a, done_a, valid_a, sop_a, eop_a, busy_a;
    logic buf_rd_b, done_b, valid_b, sop_b, eop_b, busy_b;
    logic [5:0] addr_a;
    logic [3:0] addr_b;
    logic [7:0] idx_a, idx_b;
`ifdef UNDERRUN_CNT_EN
    logic [15:0] under_a, under_b_unused;
`endif

    int checks = 0, errors = 0;
    int rdy_mode = 0, srdy_mode = 0;
    logic srdy_val = 1'b0;
    logic [1:0] hist = 2'b00;

    always #5 clock = ~clock;

    ofdm_frame_ctrl #(.N_FFT(NA), .CP_LEN(CPA), .SYMS_PER_FRAME(SA), .GAP_LEN(GA), .ADDR_W(6)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .ready_in(ready_in), .sym_rdy(sym_rdy),
`ifdef UNDERRUN_CNT_EN
        .underrun_cnt(under_a),
`endif
        .buf_rd(buf_rd_a), .buf_addr(addr_a), .sym_done(done_a), .valid_OFDM(valid_a),
        .sop(sop_a), .eop(eop_a), .sym_idx(idx_a), .frame_busy(busy_a)
    );

    ofdm_frame_ctrl #(.N_FFT(NB), .CP_LEN(CPB), .SYMS_PER_FRAME(SB), .GAP_LEN(GB), .ADDR_W(4)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .ready_in(ready_in), .sym_rdy(sym_rdy),
`ifdef UNDERRUN_CNT_EN
        .underrun_cnt(under_b_unused),
`endif
        .buf_rd(buf_rd_b), .buf_addr(addr_b), .sym_done(done_b), .valid_OFDM(valid_b),
        .sop(sop_b), .eop(eop_b), .sym_idx(idx_b), .frame_busy(busy_b)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Beat k of the continuous frame stream: symbol = k / (N+CP), CP samples first.
    function automatic void exp_beat(input int k, input int n, input int cp, input int syms,
                                     output int addr, output bit s, output bit e,
                                     output bit last, output int idx);
        int len, j, sy;
        len  = n + cp;
        sy   = k / len;
        j    = k % len;
        addr = (j < cp) ? (n - cp + j) : (j - cp);
        s    = (j == 0);
        last = (j == len - 1);
        e    = last && ((sy % syms) == syms - 1);
        idx  = sy % syms;
    endfunction

    always @(posedge clock) hist <= {hist[0], ready_in};

    int ka, pa_addr, idle_a, ea, eia;
    bit pa_rd, pa_done, aft_eop_a, esa, eea, ela;
    always @(negedge clock) begin
        if (!reset) begin
            ka = 0; pa_rd = 0; pa_done = 0; pa_addr = 0; idle_a = 0; aft_eop_a = 0;
        end else begin
            if (valid_a) begin
                exp_beat(ka, NA, CPA, SA, ea, esa, eea, ela, eia);
                check_eq("A_rd_before_valid", pa_rd, 1);
                check_eq("A_ready_latency", hist[1], 1);
                check_eq("A_addr", pa_addr, ea);
                check_eq("A_sop", sop_a, esa);
                check_eq("A_eop", eop_a, eea);
                if (esa) check_eq("A_sym_idx", idx_a, eia);
                if (ela) check_eq("A_sym_done", pa_done, 1);
                if (esa && aft_eop_a) check_eq("A_frame_gap", idle_a >= GA, 1);
                if (eea) aft_eop_a = 1; else if (esa) aft_eop_a = 0;
                idle_a = 0;
                ka++;
            end else begin
                idle_a++;
            end
            if (done_a) check_eq("A_done_at_last_rd", buf_rd_a && (addr_a == 6'(NA - 1)), 1);
            pa_rd = buf_rd_a; pa_addr = addr_a; pa_done = done_a;
        end
    end

    int kb, pb_addr, idle_b, eb, eib;
    bit pb_rd, pb_done, aft_eop_b, esb, eeb, elb;
    always @(negedge clock) begin
        if (!reset) begin
            kb = 0; pb_rd = 0; pb_done = 0; pb_addr = 0; idle_b = 0; aft_eop_b = 0;
        end else begin
            if (valid_b) begin
                exp_beat(kb, NB, CPB, SB, eb, esb, eeb, elb, eib);
                check_eq("B_rd_before_valid", pb_rd, 1);
                check_eq("B_ready_latency", hist[1], 1);
                check_eq("B_addr", pb_addr, eb);
                check_eq("B_sop", sop_b, esb);
                check_eq("B_eop", eop_b, eeb);
                if (esb) check_eq("B_sym_idx", idx_b, eib);
                if (elb) check_eq("B_sym_done", pb_done, 1);
                if (esb && aft_eop_b) check_eq("B_frame_gap", idle_b >= GB, 1);
                if (eeb) aft_eop_b = 1; else if (esb) aft_eop_b = 0;
                idle_b = 0;
                kb++;
            end else begin
                idle_b++;
            end
            if (done_b) check_eq("B_done_at_last_rd", buf_rd_b && (addr_b == 4'(NB - 1)), 1);
            pb_rd = buf_rd_b; pb_addr = addr_b; pb_done = done_b;
        end
    end

    task automatic step();
        @(negedge clock);
        case (rdy_mode)
            0: ready_in = 1'b1;
            1: ready_in = ~ready_in;
            default: ready_in = 1'($urandom_range(0, 1));
        endcase
        sym_rdy = (srdy_mode != 0) ? 1'($urandom_range(0, 1)) : srdy_val;
    endtask

    task automatic wait_sop_idx(input int idx, input int budget, output int prev_addr);
        bit hit = 0;
        prev_addr = 0;
        for (int i = 0; i < budget; i++) begin
            prev_addr = addr_a;
            step();
            if (valid_a && sop_a && (idx_a == 8'(idx))) begin
                hit = 1;
                break;
            end
        end
        check_eq("wait_sop", hit, 1);
    endtask

    task automatic wait_flag(input int which, input int budget);
        bit hit = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((which == 0) ? (valid_a && eop_a) : done_a) begin
                hit = 1;
                break;
            end
        end
        check_eq((which == 0) ? "wait_eop" : "wait_done", hit, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_buf_rd"}, buf_rd_a, 0);
        check_eq({tag, "_valid"}, valid_a, 0);
        check_eq({tag, "_sop_eop"}, {sop_a, eop_a}, 0);
        check_eq({tag, "_sym_done"}, done_a, 0);
        check_eq({tag, "_buf_addr"}, addr_a, 0);
        check_eq({tag, "_sym_idx"}, idx_a, 0);
        check_eq({tag, "_busy"}, busy_a, 0);
        check_eq({tag, "_b_outs"}, {buf_rd_b, valid_b, busy_b, addr_b, idx_b}, 0);
    endtask

    initial begin
        int n, nb, nc, nz, pa;
        bit hit;

        repeat (3) step();
        check_all_zero("reset");
        step();
        #2 reset = 1'b1;
        enable = 1'b1;
        repeat (5) step();
        check_eq("wait_sym_busy", busy_a, 1);
        check_eq("wait_sym_no_rd", buf_rd_a, 0);

        // sym_rdy goes high ahead of sampling edge E0; valid expected 2 edges after E0
        srdy_val = 1'b1;
        step();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n++;
            if (valid_a) break;
        end
        check_eq("latency_edges", n - 1, 2);

        nb = 1;
        hit = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (valid_a) nb++;
            if (valid_a && eop_a) begin hit = 1; break; end
        end
        check_eq("frame1_eop_seen", hit, 1);
        check_eq("frame1_beats", nb, SA * (NA + CPA));

        rdy_mode = 1;
        wait_sop_idx(0, 2000, pa);
        nb = 1; nc = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            nc++;
            if (valid_a && sop_a) break;
            if (valid_a) nb++;
        end
        check_eq("toggle_sym_beats", nb, NA + CPA);
        check_eq("toggle_sym_cycles_ge_160", nc >= 2 * (NA + CPA), 1);

        rdy_mode = 0;
        wait_sop_idx(2, 4000, pa);
        wait_flag(1, 500);
        srdy_val = 1'b0;
        nz = 0;
        repeat (10) begin
            step();
            if (!valid_a) nz++;
        end
        srdy_val = 1'b1;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (valid_a && sop_a) begin hit = 1; break; end
            if (!valid_a) nz++;
        end
        check_eq("underrun_sop_seen", hit, 1);
        check_eq("underrun_gap_ge_10", nz >= 10, 1);
        check_eq("underrun_next_idx", idx_a, 3);
`ifdef UNDERRUN_CNT_EN
        check_eq("underrun_cnt", under_a, 10);
`endif

        wait_sop_idx(2, 2000, pa);
        enable = 1'b0;
        wait_flag(0, 2000);
        repeat (GA + 4) step();
        check_eq("disable_idle_busy", busy_a, 0);
        n = 0;
        repeat (20) begin
            step();
            if (valid_a) n++;
        end
        check_eq("disable_no_valid", n, 0);
        hit = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy_b) begin hit = 1; break; end
            step();
        end
        check_eq("disable_b_idle", hit, 1);

        enable = 1'b1;
        rdy_mode = 2;
        srdy_mode = 1;
        repeat (1500) step();
        hit = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (buf_rd_a && (addr_a == 6'd20)) begin hit = 1; break; end
        end
        check_eq("reach_body_addr20", hit, 1);
        #2 reset = 1'b0;
        #1 check_all_zero("midreset");
        step();
        step();
        rdy_mode = 0;
        srdy_mode = 0;
        srdy_val = 1'b1;
        #2 reset = 1'b1;
        wait_sop_idx(0, 300, pa);
        check_eq("post_reset_sop_addr", pa, NA - CPA);
        check_eq("post_reset_sym_idx", idx_a, 0);
        wait_flag(0, 2000);
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
